mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its ALU result (address or ALU value), rs2 read data (store data), rd and control bits.
- Performs RISC-V RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ready data-memory interface with variable latency.
- Produces a registered writeback bundle for the register file; stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT, 255, max cycles waiting for dmem_ready before abort (1..65535).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  execute stage presents an instruction this cycle.
- alu_result  in  32  effective address (mem ops) or ALU value (others).
- rd2  in  32  store data.
- funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- stall  out  1  upstream must hold inputs stable.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address (bits [1:0] = 0).
- dmem_wdata  out  32  lane-aligned store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  memory accepts/completes request this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ready=1 and dmem_we=0.
- wb_valid  out  1  writeback bundle valid (one-cycle pulse per instruction).
- wb_we  out  1  register write enable.
- wb_rd  out  5  writeback register index.
- wb_data  out  32  writeback value.
- bus_err  out  1  one-cycle pulse on timeout (or misalign, see feature).

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, timeout counter 0.
- States IDLE, ACCESS.
- IDLE, valid_in=1, mem_read=0, mem_write=0: next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_we=reg_write; latency 1, no stall.
- IDLE, valid_in=1, mem_read|mem_write: latch addr/data/funct3/rd/ctrl; go ACCESS; stall=1 combinationally from this cycle until the completion cycle inclusive; wb_valid=0 during ACCESS.
- ACCESS: dmem_req=1, dmem_addr/we/be/wdata held stable until dmem_ready=1 sampled. On dmem_ready: return IDLE; next cycle wb_valid=1.
- Load result: byte = rdata lane addr[1:0], half = lane addr[1]; sign-extend for 000/001, zero-extend 100/101; 010 word. wb_we=reg_write.
- Store: wb_valid=1, wb_we=0. SB be=0001<<addr[1:0], wdata={4{rd2[7:0]}}; SH be=0011<<{addr[1],0}, wdata={2{rd2[15:0]}}; SW be=1111.
- funct3 011/110/111 treated as word access.
- mem_read and mem_write both set: store takes priority.
- rd=0: wb_we forced 0 in all cases.
- Timeout: counter counts ACCESS cycles; reaching TIMEOUT without dmem_ready: drop dmem_req, return IDLE, next cycle wb_valid=1, wb_we=0, bus_err=1.
- Reset mid-ACCESS: request dropped immediately, no writeback produced.
- valid_in ignored while state=ACCESS.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: halfword access with addr[0]=1 or word access with addr[1:0]!=0 issues no dmem_req; next cycle wb_valid=1, wb_we=0, bus_err=1; no stall.
- Undefined: low address bits ignored beyond lane selection (word access uses addr[31:2], halfword ignores addr[0]); no error.

Test Plan:
- ALU pass-through: valid_in=1, alu_result=25, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=25, wb_we=1, stall=0.
- LB sign-extend: addr=0x103, dmem_rdata=0x80FF_0000, dmem_ready after 3 cycles -> dmem_addr=0x100, stall held 4 cycles, wb_data=0xFFFF_FF80.
- LHU: addr=0x102, rdata=0xBEEF_1234 -> wb_data=0x0000_BEEF.
- SB: addr=0x201, rd2=0x0000_00AB -> dmem_we=1, dmem_be=0010, dmem_wdata=0xABAB_ABAB, wb_we=0.
- Timeout: TIMEOUT=4, dmem_ready never asserted -> dmem_req dropped after 4 cycles, bus_err pulse, wb_we=0.
- Reset mid-access: assert reset during ACCESS -> dmem_req=0, stall=0, wb_valid=0 immediately; rd=0 load afterwards gives wb_we=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between execute and writeback.
// Issues loads/stores on a req/ready data-memory port with variable latency,
// aligns store data/byte enables, extracts and extends load data, and emits a
// registered one-cycle writeback bundle. Stalls upstream while an access is
// outstanding and aborts an access after TIMEOUT cycles without dmem_ready.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// raise bus_err instead of silently ignoring the low address bits.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd2,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err
);
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_ACCESS = 1'b1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        rdwe_q, rdwe_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;

    logic        mem_op, is_byte, is_half, misal, rd_we;
    logic [3:0]  in_be;
    logic [31:0] in_wdata, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    assign mem_op  = mem_read | mem_write;
    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign rd_we   = reg_write && (rd != 5'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misal = (is_half && alu_result[0]) || (!is_byte && !is_half && (alu_result[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    // Lane-replicated store data and byte enables from the incoming request
    always_comb begin
        in_be    = 4'b1111;
        in_wdata = rd2;
        if (is_byte) begin
            in_be    = 4'b0001 << alu_result[1:0];
            in_wdata = {4{rd2[7:0]}};
        end else if (is_half) begin
            in_be    = 4'b0011 << {alu_result[1], 1'b0};
            in_wdata = {2{rd2[15:0]}};
        end
    end

    // Select the addressed lane of the read data and sign/zero extend
    always_comb begin
        ld_byte  = dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half  = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_val = dmem_rdata;
        if (f3_q[1:0] == 2'b00)
            load_val = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
        else if (f3_q[1:0] == 2'b01)
            load_val = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
    end

    // Next-state: accept in IDLE, wait for ready or timeout in ACCESS
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        rdwe_d     = rdwe_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        err_d      = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (!mem_op) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = rd_we;
                        wb_rd_d    = rd;
                        wb_data_d  = alu_result;
                    end else if (misal) begin
                        wb_valid_d = 1'b1;
                        err_d      = 1'b1;
                        wb_rd_d    = rd;
                        wb_data_d  = 32'd0;
                    end else begin
                        state_d = S_ACCESS;
                        addr_d  = {alu_result[31:2], 2'b00};
                        off_d   = alu_result[1:0];
                        wdata_d = in_wdata;
                        be_d    = in_be;
                        we_d    = mem_write;   // store wins if both set
                        f3_d    = funct3;
                        rd_d    = rd;
                        rdwe_d  = rd_we && !mem_write;
                        cnt_d   = 16'd0;
                    end
                end
            end
            default: begin
                if (dmem_ready) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = rdwe_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = we_q ? 32'd0 : load_val;
                end else if (cnt_q == TMO_LAST) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = 32'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    // State and writeback registers; async reset kills any pending access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            rd_q       <= '0;
            rdwe_q     <= 1'b0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            rdwe_q     <= rdwe_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign stall      = (state_q == S_ACCESS) || (valid_in && mem_op && !misal);
    assign dmem_req   = (state_q == S_ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign bus_err    = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of transactions with expected writeback pushed to
// a scoreboard queue, a negedge monitor popping it, plus reset-mid-access.
module tb_mem_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] alu_result = '0, rd2 = '0, dmem_rdata = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, dmem_ready = 1'b0;
    logic [4:0]  rd = '0;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_we, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
        .rd2(rd2), .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
        .rd(rd), .reg_write(reg_write), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, rd2, rdata;
        logic [2:0]  f3;
        logic        rdm, wrm, regw;
        logic [4:0]  rd;
        int          lat;      // ACCESS cycles before ready; -1 = never
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    typedef struct {
        logic        we, err;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] d2,
                                input logic [31:0] rdata, input logic [2:0] f3,
                                input logic rdm, input logic wrm, input logic regw,
                                input logic [4:0] r, input int lat, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] ebe);
        vec_t v;
        v.alu = alu; v.rd2 = d2; v.rdata = rdata; v.f3 = f3; v.rdm = rdm; v.wrm = wrm;
        v.regw = regw; v.rd = r; v.lat = lat; v.e_addr = ea; v.e_wdata = ewd; v.e_be = ebe;
        return v;
    endfunction

    // Scoreboard consumer: every writeback pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
        end
    end

    // Drive one transaction (called just after a negedge) and act as memory
    task automatic run_vec(input vec_t v, input wb_t e);
        int stalls;
        valid_in = 1'b1; alu_result = v.alu; rd2 = v.rd2; funct3 = v.f3;
        mem_read = v.rdm; mem_write = v.wrm; reg_write = v.regw; rd = v.rd;
        #1;
        sb.push_back(e);
        if (!(v.rdm || v.wrm)) begin
            chk("alu_stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
            chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
            valid_in = 1'b0;
        end else begin
            chk("issue_stall", {31'd0, stall}, 32'd1);
            stalls = 1;
            @(negedge clk);
            for (int i = 0; i < 300; i++) begin
                chk("dmem_req", {31'd0, dmem_req}, 32'd1);
                chk("dmem_addr", dmem_addr, v.e_addr);
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, v.wrm});
                if (v.wrm) begin
                    chk("dmem_be", {28'd0, dmem_be}, {28'd0, v.e_be});
                    chk("dmem_wdata", dmem_wdata, v.e_wdata);
                end
                if (stall) stalls++;
                if (i == v.lat) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(negedge clk);
                dmem_ready = 1'b0;
                if (i == v.lat || (v.lat < 0 && i == TMO - 1)) break;
            end
            chk("stall_cycles", stalls, (v.lat < 0) ? TMO + 1 : v.lat + 2);
            chk("req_dropped", {31'd0, dmem_req}, 32'd0);
            chk("mem_wb_valid", {31'd0, wb_valid}, 32'd1);
            valid_in = 1'b0;
        end
    endtask

    vec_t tbl[15];
    wb_t  exp_t[15];

    initial begin
        // alu, rd2, rdata, f3, rd, wr, regw, rd, lat, e_addr, e_wdata, e_be
        tbl[0]  = mk(32'd25, 0, 0, 3'b000, 0, 0, 1, 5'd5, 0, 0, 0, 0);
        tbl[1]  = mk(32'h103, 0, 32'h80FF_0000, 3'b000, 1, 0, 1, 5'd7, 2, 32'h100, 0, 0);
        tbl[2]  = mk(32'h102, 0, 32'hBEEF_1234, 3'b101, 1, 0, 1, 5'd8, 1, 32'h100, 0, 0);
        tbl[3]  = mk(32'h201, 32'h0000_00AB, 0, 3'b000, 0, 1, 1, 5'd9, 0, 32'h200, 32'hABAB_ABAB, 4'b0010);
        tbl[4]  = mk(32'h302, 32'h1234_CAFE, 0, 3'b001, 0, 1, 0, 5'd0, 3, 32'h300, 32'hCAFE_CAFE, 4'b1100);
        tbl[5]  = mk(32'h400, 32'hDEAD_BEEF, 0, 3'b010, 0, 1, 1, 5'd1, 0, 32'h400, 32'hDEAD_BEEF, 4'b1111);
        tbl[6]  = mk(32'h404, 0, 32'h1234_5678, 3'b010, 1, 0, 1, 5'd10, 0, 32'h404, 0, 0);
        tbl[7]  = mk(32'h100, 0, 32'h0000_8001, 3'b001, 1, 0, 1, 5'd11, 1, 32'h100, 0, 0);
        tbl[8]  = mk(32'h102, 0, 32'h00C3_0000, 3'b100, 1, 0, 1, 5'd12, 0, 32'h100, 0, 0);
        tbl[9]  = mk(32'h10B, 0, 32'hA5A5_A5A5, 3'b011, 1, 0, 1, 5'd13, 0, 32'h108, 0, 0);
        tbl[10] = mk(32'h500, 32'h0BAD_F00D, 0, 3'b010, 1, 1, 1, 5'd14, 1, 32'h500, 32'h0BAD_F00D, 4'b1111);
        tbl[11] = mk(32'd99, 0, 0, 3'b000, 0, 0, 1, 5'd0, 0, 0, 0, 0);
        tbl[12] = mk(32'h7777, 0, 0, 3'b000, 0, 0, 0, 5'd3, 0, 0, 0, 0);
        tbl[13] = mk(32'h600, 0, 0, 3'b010, 1, 0, 1, 5'd15, -1, 32'h600, 0, 0);
        tbl[14] = mk(32'h102, 0, 32'h7FFF_0000, 3'b001, 1, 0, 1, 5'd16, 0, 32'h100, 0, 0);
        // expected writeback: we, err, rd, data
        exp_t[0]  = '{1'b1, 1'b0, 5'd5,  32'd25};
        exp_t[1]  = '{1'b1, 1'b0, 5'd7,  32'hFFFF_FF80};
        exp_t[2]  = '{1'b1, 1'b0, 5'd8,  32'h0000_BEEF};
        exp_t[3]  = '{1'b0, 1'b0, 5'd9,  32'd0};
        exp_t[4]  = '{1'b0, 1'b0, 5'd0,  32'd0};
        exp_t[5]  = '{1'b0, 1'b0, 5'd1,  32'd0};
        exp_t[6]  = '{1'b1, 1'b0, 5'd10, 32'h1234_5678};
        exp_t[7]  = '{1'b1, 1'b0, 5'd11, 32'hFFFF_8001};
        exp_t[8]  = '{1'b1, 1'b0, 5'd12, 32'h0000_00C3};
        exp_t[9]  = '{1'b1, 1'b0, 5'd13, 32'hA5A5_A5A5};
        exp_t[10] = '{1'b0, 1'b0, 5'd14, 32'd0};
        exp_t[11] = '{1'b0, 1'b0, 5'd0,  32'd99};
        exp_t[12] = '{1'b0, 1'b0, 5'd3,  32'h7777};
        exp_t[13] = '{1'b0, 1'b1, 5'd15, 32'd0};
        exp_t[14] = '{1'b1, 1'b0, 5'd16, 32'h0000_7FFF};

        // Reset state
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 15; k++) run_vec(tbl[k], exp_t[k]);
        @(negedge clk);
        chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Reset in the middle of an access: request gone, no writeback
        valid_in = 1'b1; alu_result = 32'h700; funct3 = 3'b010;
        mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; rd = 5'd9;
        @(negedge clk);
        chk("mid_req", {31'd0, dmem_req}, 32'd1);
        valid_in = 1'b0; mem_read = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Load to x0 after reset: completes with write-enable suppressed
        run_vec(mk(32'h800, 0, 32'h1111_2222, 3'b010, 1, 0, 1, 5'd0, 1, 32'h800, 0, 0),
                '{1'b0, 1'b0, 5'd0, 32'h1111_2222});
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
